// File: rtl/rice_pkg.sv
// Shared constants and FSM encoding for the Rice codeword decoder.
package rice_pkg;

  localparam int unsigned DW       = 32;
  localparam int unsigned KW       = 4;
  localparam int unsigned BUF_W    = 96;
  localparam int unsigned FILL_LO  = 48;
  localparam int unsigned LOAD_MAX = 64;
  localparam int unsigned FILL_W   = 7;

  typedef enum logic [2:0] {
    StFill,
    StScan,
    StWait,
    StExtract,
    StHold,
    StErr
  } state_e;

endpackage

// File: rtl/rice_decode_ctrl_if.sv
// Bitstream, pencoder and sample handshake bundle for rice_decode_ctrl.
interface rice_decode_ctrl_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned KW = 4
);
  logic          word_valid;
  logic          word_ready;
  logic [DW-1:0] word_data;
  logic [KW-1:0] k_param;
  logic          pe_en;
  logic [DW-1:0] pe_in;
  logic [4:0]    pe_len;
  logic [4:0]    pe_out;
  logic          samp_valid;
  logic          samp_ready;
  logic [DW-1:0] samp_data;
  logic          err;

  // Decoder side.
  modport slave (
    input  word_valid, word_data, k_param, pe_len, pe_out, samp_ready,
    output word_ready, pe_en, pe_in, samp_valid, samp_data, err
  );

  // Stream source / pencoder / sample sink side.
  modport master (
    output word_valid, word_data, k_param, pe_len, pe_out, samp_ready,
    input  word_ready, pe_en, pe_in, samp_valid, samp_data, err
  );
endinterface

// File: rtl/rice_bitbuf.sv
// MSB-aligned bit buffer with fill count: appends whole words below the valid bits,
// consumes a variable number of bits from the top.
module rice_bitbuf #(
  parameter int unsigned BW = rice_pkg::BUF_W,
  parameter int unsigned DW = rice_pkg::DW,
  parameter int unsigned FW = rice_pkg::FILL_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          shift,
  input  logic [FW-1:0] total,
  output logic [BW-1:0] bits,
  output logic [FW-1:0] fill
);

  always_ff @(posedge clk) begin
    if (reset) begin
      bits <= '0;
      fill <= '0;
    end else if (load) begin
      // Bits below the fill point are always zero, so OR places the word at bits[BW-1-fill -: DW].
      bits <= bits | ({load_data, {(BW-DW){1'b0}}} >> fill);
      fill <= fill + FW'(DW);
    end else if (shift) begin
      bits <= bits << total;
      fill <= fill - total;
    end
  end

endmodule

// File: rtl/rice_decode_ctrl.sv
// Rice codeword decoder control: buffers stream words, uses an external leading-zero
// encoder for the unary quotient, then extracts the k-bit remainder.
module rice_decode_ctrl #(
  parameter int unsigned DW = rice_pkg::DW,
  parameter int unsigned KW = rice_pkg::KW
) (
  input logic               clk,
  input logic               reset,
  rice_decode_ctrl_if.slave bus
);
  import rice_pkg::*;

  localparam int unsigned FW = FILL_W;
  localparam int unsigned RW = 1 << KW;
  localparam logic [FW-1:0] FillLo  = FW'(FILL_LO);
  localparam logic [FW-1:0] LoadMax = FW'(LOAD_MAX);

  state_e          state_q;
  logic            word_ready_q;
  logic            err_q;
  logic [KW-1:0]   k_q;
  logic [4:0]      q_q;
  logic [DW-1:0]   samp_q;

  logic [BUF_W-1:0] bits;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_n;
  logic [DW-1:0]    hi;
  logic [BUF_W-1:0] shifted;
  logic [RW-1:0]    rwin;
  logic [RW-1:0]    rval;
  logic [FW-1:0]    total;
  logic [2*DW-1:0]  wide;
  logic [DW-1:0]    samp_next;
  logic             load;
  logic             shift;
  logic             unused_pe_out;

  rice_bitbuf #(
    .BW (BUF_W),
    .DW (DW),
    .FW (FW)
  ) u_bitbuf (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (bus.word_data),
    .shift     (shift),
    .total     (total),
    .bits      (bits),
    .fill      (fill)
  );

  always_comb begin
    load    = (state_q == StFill) && bus.word_valid && word_ready_q;
    shift   = (state_q == StExtract);
    fill_n  = load ? fill + FW'(DW) : fill;
    hi      = bits[BUF_W-1 -: DW];
    // Drop the quotient zeros and the terminating one; remainder is the top k bits left.
    shifted = bits << (6'(q_q) + 6'd1);
    rwin    = shifted[BUF_W-1 -: RW];
    rval    = rwin >> (RW - 32'(k_q));
    total   = FW'(q_q) + FW'(k_q) + FW'(1);
    wide    = (2*DW)'(q_q) << k_q;
    samp_next = wide[DW-1:0] | DW'(rval);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFill;
      word_ready_q <= 1'b0;
      err_q        <= 1'b0;
      k_q          <= '0;
      q_q          <= '0;
      samp_q       <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (fill_n >= FillLo) begin
            state_q      <= StScan;
            word_ready_q <= 1'b0;
          end else begin
            word_ready_q <= (fill_n <= LoadMax);
          end
        end
        StScan: begin
          k_q     <= bus.k_param;
          state_q <= (hi == '0) ? StErr : StWait;
        end
        StWait: begin
          q_q     <= bus.pe_len;
          state_q <= StExtract;
        end
        StExtract: begin
          samp_q  <= samp_next;
          state_q <= StHold;
        end
        StHold: begin
          if (bus.samp_ready) begin
            if (fill >= FillLo) begin
              state_q <= StScan;
            end else begin
              state_q      <= StFill;
              word_ready_q <= (fill <= LoadMax);
            end
          end
        end
        StErr: begin
          err_q <= 1'b1;
        end
        default: begin
          state_q      <= StFill;
          word_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.word_ready = word_ready_q;
  assign bus.pe_en      = (state_q == StScan);
  assign bus.pe_in      = (state_q == StScan) ? hi : '0;
  assign bus.samp_valid = (state_q == StHold);
  assign bus.samp_data  = samp_q;
  assign bus.err        = err_q;
  assign unused_pe_out  = ^bus.pe_out;

endmodule

// File: tb/tb_rice_decode_ctrl.sv
// Directed bench for rice_decode_ctrl with a registered leading-zero pencoder model
// and a queue scoreboard of expected samples and post-consume fill levels.
module tb_rice_decode_ctrl;
  import rice_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [31:0] exp_q[$];
  logic [31:0] fill_q[$];
  logic [31:0] wq[$];

  rice_decode_ctrl_if #(.DW(32), .KW(4)) bus ();

  rice_decode_ctrl #(
    .DW (32),
    .KW (4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] lzc(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) return 5'(31 - i);
    end
    return 5'd0;
  endfunction

  // Pencoder: leading-zero count registered one cycle after pe_en.
  always @(posedge clk) begin
    if (reset) begin
      bus.pe_len <= 5'd0;
      bus.pe_out <= 5'd0;
    end else if (bus.pe_en) begin
      bus.pe_len <= lzc(bus.pe_in);
      bus.pe_out <= 5'(31 - 32'(lzc(bus.pe_in)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    tick();
    reset = 1'b0;
    chk("rst_word_ready", 32'(bus.word_ready), 32'd0);
    chk("rst_samp_valid", 32'(bus.samp_valid), 32'd0);
    chk("rst_samp_data", bus.samp_data, 32'd0);
    chk("rst_pe_en", 32'(bus.pe_en), 32'd0);
    chk("rst_pe_in", bus.pe_in, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_fill", 32'(u_dut.u_bitbuf.fill), 32'd0);
    tick();
    chk("fill_word_ready", 32'(bus.word_ready), 32'd1);
  endtask

  task automatic feed(input logic [31:0] w0, input logic [31:0] w1);
    logic fire;
    int   cyc;
    wq.push_back(w0);
    wq.push_back(w1);
    cyc = 0;
    while (wq.size() > 0 && cyc < 50) begin
      bus.word_valid = 1'b1;
      bus.word_data  = wq[0];
      fire = bus.word_ready;
      tick();
      cyc++;
      if (fire) void'(wq.pop_front());
    end
    bus.word_valid = 1'b0;
    chk("words_accepted", 32'(wq.size()), 32'd0);
    wq.delete();
  endtask

  // Drains n samples; k_param is scrambled while each codeword is in flight.
  task automatic collect(input int n, input logic [3:0] kk);
    int   got;
    int   cyc;
    logic scr;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 300) begin
      scr = bus.pe_en;
      if (bus.samp_valid && bus.samp_ready) begin
        chk("samp_data", bus.samp_data, exp_q.pop_front());
        chk("fill", 32'(u_dut.u_bitbuf.fill), fill_q.pop_front());
        bus.k_param = kk;
        got++;
      end
      tick();
      cyc++;
      if (scr) bus.k_param = ~kk;
    end
    bus.k_param = kk;
    chk("samples_received", 32'(got), 32'(n));
    exp_q.delete();
    fill_q.delete();
  endtask

  task automatic wait_valid();
    int cyc;
    cyc = 0;
    while (!bus.samp_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("samp_valid_seen", 32'(bus.samp_valid), 32'd1);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    bus.samp_ready = 1'b1;
    bus.k_param    = 4'd0;

    // k=2: 0010_1100... -> q=2 r=01 -> 9, then q=0 r=00 -> 0.
    do_reset();
    bus.k_param = 4'd2;
    exp_q.push_back(32'd9);  fill_q.push_back(32'd59);
    exp_q.push_back(32'd0);  fill_q.push_back(32'd56);
    feed(32'h2C00_0000, 32'h0000_0000);
    collect(2, 4'd2);

    // k=0: single-bit codeword, then 31 zeros + terminator.
    do_reset();
    bus.k_param = 4'd0;
    exp_q.push_back(32'd0);  fill_q.push_back(32'd63);
    exp_q.push_back(32'd31); fill_q.push_back(32'd31);
    feed(32'h8000_0000, 32'hFFFF_FFFF);
    collect(2, 4'd0);

    // k=4: maximum quotient within the window, q=31 r=1010.
    do_reset();
    bus.k_param = 4'd4;
    exp_q.push_back(32'd506); fill_q.push_back(32'd28);
    feed(32'h0000_0001, 32'hA000_0000);
    collect(1, 4'd4);

    // All-zero window -> sticky error.
    do_reset();
    feed(32'h0000_0000, 32'h0000_0000);
    chk("err_scan_pe_en", 32'(bus.pe_en), 32'd1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("err_flag", 32'(bus.err), 32'd1);
      chk("err_word_ready", 32'(bus.word_ready), 32'd0);
      chk("err_samp_valid", 32'(bus.samp_valid), 32'd0);
      tick();
    end

    // Backpressure in HOLD for 5 cycles.
    do_reset();
    bus.k_param    = 4'd2;
    bus.samp_ready = 1'b0;
    feed(32'h2C00_0000, 32'h0000_0000);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_samp_valid", 32'(bus.samp_valid), 32'd1);
      chk("bp_samp_data", bus.samp_data, 32'd9);
      chk("bp_word_ready", 32'(bus.word_ready), 32'd0);
      tick();
    end
    bus.samp_ready = 1'b1;
    exp_q.push_back(32'd9);  fill_q.push_back(32'd59);
    exp_q.push_back(32'd0);  fill_q.push_back(32'd56);
    collect(2, 4'd2);

    // Reset while HOLD is backpressured, then a fresh stream.
    do_reset();
    bus.k_param    = 4'd2;
    bus.samp_ready = 1'b0;
    feed(32'h2C00_0000, 32'h0000_0000);
    wait_valid();
    do_reset();
    chk("mid_hold_state", 32'(u_dut.state_q), 32'(StFill));
    chk("mid_hold_samp_valid", 32'(bus.samp_valid), 32'd0);
    bus.samp_ready = 1'b1;
    bus.k_param    = 4'd4;
    exp_q.push_back(32'd506); fill_q.push_back(32'd28);
    feed(32'h0000_0001, 32'hA000_0000);
    collect(1, 4'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

endmodule
